// File: rtl/tt_um_and_sched.sv
// Round-robin arbiter for four requesters feeding a single 4-bit AND unit.
// The winner's operands are latched, ANDed, and the result is held until ack arrives or the timeout expires.
module tt_um_and_sched #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic [3:0] result_q, result_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic [2:0] done_cnt_q, done_cnt_d;
  logic       err_sticky_q, err_sticky_d;

  logic [3:0] req;
  logic       ack;
  logic       status_sel;
  logic       busy;
  logic       valid;
  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] idx;

  assign req        = ui_in[3:0];
  assign ack        = ui_in[4];
  assign status_sel = ui_in[5];

  // First asserted request at or above ptr, wrapping 3 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    idx       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_id_d     = gnt_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    to_cnt_d     = to_cnt_q;
    done_cnt_d   = done_cnt_q;
    err_sticky_d = err_sticky_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            gnt_id_d = win_id;
            state_d  = GRANT;
          end
        end
        GRANT: begin
          op_a_d  = uio_in[7:4];
          op_b_d  = uio_in[3:0];
          state_d = EXEC;
        end
        EXEC: begin
          result_d = op_a_q & op_b_q;
          to_cnt_d = 8'd0;
          state_d  = DONE;
        end
        default: begin
          // Ack wins over a simultaneous timeout and leaves err_sticky alone.
          if (ack) begin
            state_d    = IDLE;
            ptr_d      = gnt_id_q + 2'd1;
            done_cnt_d = done_cnt_q + 3'd1;
            to_cnt_d   = 8'd0;
          end else if (to_cnt_q == TO_LAST) begin
            state_d      = IDLE;
            ptr_d        = gnt_id_q + 2'd1;
            err_sticky_d = 1'b1;
            to_cnt_d     = 8'd0;
          end else begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd0;
      gnt_id_q     <= 2'd0;
      op_a_q       <= 4'd0;
      op_b_q       <= 4'd0;
      result_q     <= 4'd0;
      to_cnt_q     <= 8'd0;
      done_cnt_q   <= 3'd0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_id_q     <= gnt_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      to_cnt_q     <= to_cnt_d;
      done_cnt_q   <= done_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign valid = (state_q == DONE);

  always_comb begin
    uo_out      = 8'h00;
    uo_out[7]   = valid;
    uo_out[6]   = busy;
    uo_out[5:4] = busy ? gnt_id_q : 2'd0;
    if (status_sel) begin
      uo_out[3:0] = {err_sticky_q, done_cnt_q};
    end else if (valid) begin
      uo_out[3:0] = result_q;
    end
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_and_sched.sv
// Bench for tt_um_and_sched: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model (age since grant, not FSM states).
module tb_tt_um_and_sched;

  localparam int TO = 16;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_fail;

  tt_um_and_sched #(.TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: age counts enabled edges since the grant (0 = no transaction,
  // 1 = operands due, 2 = computing, 3+ = result presented).
  int m_age, m_id, m_ptr, m_a, m_b, m_res, m_done_cycles, m_done_cnt, m_err;

  task automatic model_clear();
    m_age = 0; m_id = 0; m_ptr = 0; m_a = 0; m_b = 0; m_res = 0;
    m_done_cycles = 0; m_done_cnt = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit found;
    int c;
    if (m_age == 0) begin
      found = 0;
      for (int i = 0; i < 4; i++) begin
        c = (m_ptr + i) % 4;
        if (!found && ui_in[c]) begin
          found = 1;
          m_id  = c;
        end
      end
      if (found) m_age = 1;
    end else if (m_age == 1) begin
      m_a   = int'(uio_in[7:4]);
      m_b   = int'(uio_in[3:0]);
      m_age = 2;
    end else if (m_age == 2) begin
      m_res = m_a & m_b;
      m_done_cycles = 0;
      m_age = 3;
    end else begin
      m_done_cycles++;
      if (ui_in[4]) begin
        m_done_cnt = (m_done_cnt + 1) % 8;
        m_ptr = (m_id + 1) % 4;
        m_age = 0;
      end else if (m_done_cycles == TO) begin
        m_err = 1;
        m_ptr = (m_id + 1) % 4;
        m_age = 0;
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [7:0] o;
    bit busy, valid;
    busy  = (m_age > 0);
    valid = (m_age >= 3);
    o = 8'h00;
    o[7] = valid;
    o[6] = busy;
    o[5:4] = busy ? 2'(m_id) : 2'd0;
    if (ui_in[5]) o[3:0] = {1'(m_err), 3'(m_done_cnt)};
    else if (valid) o[3:0] = 4'(m_res);
    return o;
  endfunction

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else if (ena) model_step();
    end
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model uo_out", int'(uo_out), int'(model_out()));
    checkOutput("uio_out", int'(uio_out), 0);
    checkOutput("uio_oe", int'(uio_oe), 0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [7:0] ui, input logic [7:0] uio, input logic en);
    ui_in  = ui;
    uio_in = uio;
    ena    = en;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    applyStimulus(8'h00, 8'h00, 1'b1);
    tick();
    rst_n = 1'b1;
  endtask

  int cnt;
  int guard;
  int ack_div;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    applyStimulus(8'h00, 8'h00, 1'b1);
    #1;
    checkOutput("reset uo_out", int'(uo_out), 8'h00);
    tick();
    rst_n = 1'b1;

    // Single request from requester 1
    applyStimulus(8'h02, 8'hC6, 1'b1);
    tick(); checkOutput("single grant", int'(uo_out), 8'h50);
    applyStimulus(8'h00, 8'hC6, 1'b1);
    tick(); checkOutput("single exec", int'(uo_out), 8'h50);
    tick(); checkOutput("single done", int'(uo_out), 8'hD4);
    applyStimulus(8'h10, 8'h00, 1'b1);
    tick(); checkOutput("single ack release", int'(uo_out), 8'h00);
    applyStimulus(8'h20, 8'h00, 1'b1);
    #1; checkOutput("single status", int'(uo_out), 8'h01);

    // Round robin with all requests held
    do_reset();
    for (int t = 0; t < 5; t++) begin
      applyStimulus(8'h0F, 8'hFF, 1'b1);
      tick(); tick(); tick();
      checkOutput("rr grant id", int'(uo_out[5:4]), t % 4);
      checkOutput("rr valid", int'(uo_out[7]), 1);
      applyStimulus(8'h1F, 8'hFF, 1'b1);
      tick();
    end

    // Timeout without ack
    do_reset();
    applyStimulus(8'h01, 8'h55, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h55, 1'b1);
    tick(); tick();
    cnt = 0;
    guard = 0;
    while (uo_out[7] && guard < 40) begin
      cnt++; guard++;
      tick();
    end
    checkOutput("timeout valid cycles", cnt, 16);
    checkOutput("timeout idle", int'(uo_out), 8'h00);
    applyStimulus(8'h20, 8'h00, 1'b1);
    #1; checkOutput("timeout status", int'(uo_out), 8'h08);

    // Ack on the last DONE cycle beats the timeout
    do_reset();
    applyStimulus(8'h01, 8'h77, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h77, 1'b1);
    tick(); tick();
    for (int t = 0; t < TO - 1; t++) tick();
    checkOutput("ack-vs-to still valid", int'(uo_out), 8'hC7);
    applyStimulus(8'h10, 8'h00, 1'b1);
    tick(); checkOutput("ack-vs-to release", int'(uo_out), 8'h00);
    applyStimulus(8'h20, 8'h00, 1'b1);
    #1; checkOutput("ack-vs-to status", int'(uo_out), 8'h01);

    // Enable freeze during EXEC
    do_reset();
    applyStimulus(8'h08, 8'h9C, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h9C, 1'b1);
    tick(); checkOutput("freeze exec", int'(uo_out), 8'h70);
    for (int t = 0; t < 5; t++) begin
      applyStimulus(8'h10, 8'h00, 1'b0);
      tick(); checkOutput("freeze hold", int'(uo_out), 8'h70);
    end
    applyStimulus(8'h00, 8'h00, 1'b1);
    tick(); checkOutput("freeze done", int'(uo_out), 8'hF8);

    // Reset in the middle of a DONE with ID=2
    do_reset();
    applyStimulus(8'h04, 8'h33, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h33, 1'b1);
    tick(); tick();
    checkOutput("midreset done", int'(uo_out), 8'hE3);
    rst_n = 1'b0;
    #1; checkOutput("midreset async", int'(uo_out), 8'h00);
    tick();
    rst_n = 1'b1;
    applyStimulus(8'h0C, 8'h00, 1'b1);
    tick(); checkOutput("midreset regrant", int'(uo_out), 8'h60);

    // Random traffic, frequent acks first, then rare acks to exercise timeouts
    for (int seg = 0; seg < 2; seg++) begin
      ack_div = (seg == 0) ? 3 : 40;
      for (int t = 0; t < 1500; t++) begin
        applyStimulus({2'($urandom), 1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, ack_div - 1) == 0), 4'($urandom)},
                      8'($urandom), 1'($urandom_range(0, 7) != 0));
        rst_n = ($urandom_range(0, 299) != 0);
        tick();
        rst_n = 1'b1;
      end
    end

    tick();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
